// File: rtl/spi_shift_engine_pkg.sv
// Shared types and helpers for the SPI shift engine.
package spi_shift_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A frame length of 0, or one longer than the shifter, means a full-width frame.
    function automatic int norm_len(input int len, input int max_len);
        if (len == 0 || len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/spi_shift_engine_bitcnt.sv
// Bit down-counter: loaded with the frame length, decremented per shifted bit,
// flags the last bit of the frame.
module spi_shift_engine_bitcnt #(
    parameter int CBITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CBITS-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_is_one
);

    logic [CBITS-1:0] r_cnt;

    // Count register: load wins over decrement, never wraps below zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_is_one = (r_cnt == CBITS'(1));

endmodule

// File: rtl/spi_shift_engine.sv
// SPI shift engine: accepts a parallel word, shifts it out one bit per
// shift_en strobe while sampling sin, then presents the received word.
// Optional feature macro: SPI_SHIFT_ENGINE_LSB_FIRST_EN adds the lsb_first
// port selecting per-frame bit order; without it frames are MSB-first.
module spi_shift_engine
    import spi_shift_engine_pkg::*;
#(
    parameter int nbits = 8,
    parameter int cbits = $clog2(nbits) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [nbits-1:0] req_data,
    input  logic [cbits-1:0] req_len,
    input  logic             shift_en,
    input  logic             sin,
    output logic             sout,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [nbits-1:0] resp_data,
    output logic             busy
`ifdef SPI_SHIFT_ENGINE_LSB_FIRST_EN
    ,
    input  logic             lsb_first
`endif
);

    state_t           r_state;
    state_t           w_next;
    logic [nbits-1:0] r_shreg;
    logic [cbits-1:0] r_len;
    logic             r_lsb;

    logic             w_accept;
    logic             w_strobe;
    logic             w_cnt_is_one;
    logic             w_lsb_in;
    logic [cbits-1:0] w_len_norm;
    logic [nbits-1:0] w_mask;
    logic [nbits-1:0] w_resp;
    logic             w_sout;

`ifdef SPI_SHIFT_ENGINE_LSB_FIRST_EN
    assign w_lsb_in = lsb_first;
`else
    assign w_lsb_in = 1'b0;
`endif

    assign w_len_norm = cbits'(norm_len(int'(req_len), nbits));

    spi_shift_engine_bitcnt #(
        .CBITS (cbits)
    ) u_bitcnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_val (w_len_norm),
        .i_dec      (w_strobe),
        .o_is_one   (w_cnt_is_one)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode; strobes are only honoured in SHIFT.
    always_comb begin
        w_next   = r_state;
        req_rdy  = 1'b0;
        resp_val = 1'b0;
        busy     = 1'b1;
        w_accept = 1'b0;
        w_strobe = 1'b0;
        case (r_state)
            IDLE: begin
                req_rdy = 1'b1;
                busy    = 1'b0;
                if (req_val) begin
                    w_accept = 1'b1;
                    w_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    w_strobe = 1'b1;
                    if (w_cnt_is_one) begin
                        w_next = DONE;
                    end
                end
            end
            DONE: begin
                resp_val = 1'b1;
                if (resp_rdy) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Shift register: MSB-first frames are left-aligned at load so the first
    // bit out is always the top bit; LSB-first frames load as-is.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg <= '0;
            r_len   <= '0;
            r_lsb   <= 1'b0;
        end else if (w_accept) begin
            r_len <= w_len_norm;
            r_lsb <= w_lsb_in;
            if (w_lsb_in) begin
                r_shreg <= req_data;
            end else begin
                r_shreg <= req_data << (nbits - int'(w_len_norm));
            end
        end else if (w_strobe) begin
            if (r_lsb) begin
                r_shreg <= {sin, r_shreg[nbits-1:1]};
            end else begin
                r_shreg <= {r_shreg[nbits-2:0], sin};
            end
        end
    end

    // Received-word extraction: right-justify the L received bits.
    always_comb begin
        for (int i = 0; i < nbits; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
        if (r_lsb) begin
            w_resp = r_shreg >> (nbits - int'(r_len));
        end else begin
            w_resp = r_shreg & w_mask;
        end
    end

    // Serial output is only driven while a frame is shifting.
    always_comb begin
        w_sout = 1'b0;
        if (r_state == SHIFT) begin
            w_sout = r_lsb ? r_shreg[0] : r_shreg[nbits-1];
        end
    end

    assign sout      = w_sout;
    assign resp_data = (r_state == DONE) ? w_resp : '0;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine (nbits=8).
module tb_spi_shift_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_val;
    logic       req_rdy;
    logic [7:0] req_data;
    logic [3:0] req_len;
    logic       shift_en;
    logic       sin;
    logic       sout;
    logic       resp_val;
    logic       resp_rdy;
    logic [7:0] resp_data;
    logic       busy;
`ifdef SPI_SHIFT_ENGINE_LSB_FIRST_EN
    logic       lsb_first;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // expected output state, maintained by the stimulus/model below
    logic       e_rdy, e_val, e_busy, e_sout, e_rchk;
    logic [7:0] e_resp;
    logic       cap_sout;
    logic [7:0] cap_resp;

    always #5 clk = ~clk;

    spi_shift_engine #(.nbits(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .req_data  (req_data),
        .req_len   (req_len),
        .shift_en  (shift_en),
        .sin       (sin),
        .sout      (sout),
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy),
        .resp_data (resp_data),
        .busy      (busy)
`ifdef SPI_SHIFT_ENGINE_LSB_FIRST_EN
        ,
        .lsb_first (lsb_first)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model expectations
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_rdy", 32'(req_rdy), 32'(e_rdy));
            check("resp_val", 32'(resp_val), 32'(e_val));
            check("busy", 32'(busy), 32'(e_busy));
            check("sout", 32'(sout), 32'(e_sout));
            if (e_rchk) check("resp_data", 32'(resp_data), 32'(e_resp));
        end
    end

    task automatic cycle();
        @(negedge clk);
        cap_sout = sout;
        cap_resp = resp_data;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        e_rdy  = 1'b1;
        e_val  = 1'b0;
        e_busy = 1'b0;
        e_sout = 1'b0;
        e_rchk = 1'b0;
    endtask

    // One frame. sin_v / lit_sout list bits in time order, first bit at [L-1].
    task automatic frame(input logic [7:0] data, input logic [3:0] len,
                         input logic [7:0] sin_v, input int gap, input bit lsb,
                         input int hold, input int abort_at,
                         input logic [7:0] lit_resp, input logic [7:0] lit_sout);
        int         L;
        logic [7:0] seq;
        logic [7:0] m_resp;
        logic [7:0] got_sout;
        L = (len == 4'd0 || len > 4'd8) ? 8 : int'(len);
        seq = '0;
        m_resp = '0;
        got_sout = '0;
        for (int k = 0; k < L; k++) begin
            seq[k] = lsb ? data[k] : data[L-1-k];
            if (lsb) m_resp[k] = sin_v[L-1-k];
            else     m_resp[L-1-k] = sin_v[L-1-k];
        end
        // accept cycle, with a stray strobe that must be ignored
        set_idle();
        req_val  = 1'b1;
        req_data = data;
        req_len  = len;
`ifdef SPI_SHIFT_ENGINE_LSB_FIRST_EN
        lsb_first = lsb;
`endif
        shift_en = 1'b1;
        sin      = 1'b1;
        cycle();
        req_val  = 1'b0;
        shift_en = 1'b0;
        req_data = 8'h00;
        e_rdy  = 1'b0;
        e_busy = 1'b1;
        e_sout = seq[0];
        cycle();
        for (int k = 0; k < L; k++) begin
            if (k == abort_at) begin
                reset = 1'b1;
                cycle();
                reset = 1'b0;
                set_idle();
                e_rchk = 1'b1;
                e_resp = 8'h00;
                cycle();
                e_rchk = 1'b0;
                return;
            end
            shift_en = 1'b1;
            sin      = sin_v[L-1-k];
            e_sout   = seq[k];
            cycle();
            got_sout[L-1-k] = cap_sout;
            shift_en = 1'b0;
            if (k < L - 1) begin
                e_sout = seq[k+1];
                repeat (gap) cycle();
            end
        end
        // DONE: held while resp_rdy is low, strobes and requests ignored
        e_val  = 1'b1;
        e_sout = 1'b0;
        e_rchk = 1'b1;
        e_resp = m_resp;
        for (int h = 0; h < hold; h++) begin
            shift_en = (h % 2 == 0);
            req_val  = 1'b1;
            cycle();
        end
        shift_en = 1'b0;
        req_val  = 1'b0;
        resp_rdy = 1'b1;
        cycle();
        resp_rdy = 1'b0;
        set_idle();
        check("sout_seq", 32'(got_sout), 32'(lit_sout));
        check("resp_lit", 32'(cap_resp), 32'(lit_resp));
    endtask

    initial begin
        reset    = 1'b1;
        req_val  = 1'b0;
        req_data = 8'h00;
        req_len  = 4'd0;
        shift_en = 1'b0;
        sin      = 1'b0;
        resp_rdy = 1'b0;
`ifdef SPI_SHIFT_ENGINE_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        set_idle();
        e_rchk = 1'b1;
        e_resp = 8'h00;
        chk_en = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        set_idle();

        frame(8'hA5, 4'd8,  8'b0011_1100, 0, 1'b0, 0, -1, 8'h3C, 8'hA5);
        frame(8'h0B, 4'd4,  8'b0000_1100, 2, 1'b0, 0, -1, 8'h0C, 8'h0B);
        frame(8'hFF, 4'd0,  8'h00,        0, 1'b0, 0, -1, 8'h00, 8'hFF);
        frame(8'h5A, 4'd12, 8'h96,        0, 1'b0, 5, -1, 8'h96, 8'h5A);
        frame(8'hC3, 4'd8,  8'hFF,        0, 1'b0, 0,  3, 8'h00, 8'h00);
        frame(8'h02, 4'd2,  8'b0000_0010, 0, 1'b0, 0, -1, 8'h02, 8'h02);
        frame(8'h07, 4'd1,  8'b0000_0001, 1, 1'b0, 0, -1, 8'h01, 8'h01);
`ifdef SPI_SHIFT_ENGINE_LSB_FIRST_EN
        frame(8'h01, 4'd8,  8'b1000_0000, 0, 1'b1, 0, -1, 8'h01, 8'h80);
        frame(8'h0B, 4'd4,  8'b0000_1100, 1, 1'b1, 2, -1, 8'h03, 8'h0D);
`endif
        cycle();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
